// File: rtl/reg_file_pkg.sv
// Shared encodings and helpers for the register file and its pending-write scoreboard.
package reg_file_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_NONE = 2'd3
  } wb_sel_t;

  // x0 and addresses beyond NREG (non power-of-two files) are never stored or tracked
  function automatic logic addr_valid(input int unsigned addr, input int unsigned nreg);
    return (addr != 0) && (addr < nreg);
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write counters per register; drives iss_ready and per-port RAW busy flags.
// Optional REG_FILE_BYPASS_EN: a forwarded last write clears busy in its own cycle.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int NUM_RD = 2,
  parameter int PEND_W = 2,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rs_addr,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_rd,
  output logic                 iss_ready,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
`ifdef REG_FILE_BYPASS_EN
  input  logic                 fwd_en,
`endif
  output logic [NUM_RD-1:0]    rs_busy
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0] pend [NREG];
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;

  always_comb begin
    iss_ready = 1'b1;
    if (addr_valid(32'(iss_rd), NREG))
      iss_ready = (pend[iss_rd] != PEND_MAX);
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (iss_en && iss_ready && addr_valid(32'(iss_rd), NREG))
      inc_vec[iss_rd] = 1'b1;
    if (wb_en && addr_valid(32'(wb_addr), NREG))
      dec_vec[wb_addr] = 1'b1;
  end

  // Issue and retire hitting the same register cancel; counters saturate at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          pend[r] <= pend[r] + 1'b1;
        else if (dec_vec[r] && !inc_vec[r] && pend[r] != '0)
          pend[r] <= pend[r] - 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    logic [AW-1:0] addr;
    assign addr = rs_addr[i*AW +: AW];

    always_comb begin
      rs_busy[i] = 1'b0;
      if (addr_valid(32'(addr), NREG)) begin
        rs_busy[i] = (pend[addr] != '0);
`ifdef REG_FILE_BYPASS_EN
        if (fwd_en && wb_addr == addr && pend[addr] == PEND_ONE)
          rs_busy[i] = 1'b0;
`endif
      end
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with writeback source mux, pending-write scoreboard and read ports.
// Optional REG_FILE_BYPASS_EN forwards the writeback value to matching read ports.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NUM_RD = 2,
  parameter int PEND_W = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_data,
  output logic [NUM_RD-1:0]      rs_busy,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_rd,
  output logic                   iss_ready,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_addr,
  input  logic [1:0]             wb_sel,
  input  logic [XLEN-1:0]        wb_alu,
  input  logic [XLEN-1:0]        wb_mem,
  input  logic [XLEN-1:0]        wb_link
);

  wb_sel_t         sel;
  logic [XLEN-1:0] wb_val;
  logic            wr_en;
  logic [XLEN-1:0] regs [NREG];

  assign sel   = wb_sel_t'(wb_sel);
  assign wr_en = wb_en && (sel != WB_NONE) && addr_valid(32'(wb_addr), NREG);

  always_comb begin
    wb_val = '0;
    case (sel)
      WB_ALU:  wb_val = wb_alu;
      WB_MEM:  wb_val = wb_mem;
      WB_LINK: wb_val = wb_link;
      default: wb_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (wr_en) begin
      regs[wb_addr] <= wb_val;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    assign addr = rs_addr[i*AW +: AW];

    always_comb begin
      data = '0;
      if (addr_valid(32'(addr), NREG))
        data = regs[addr];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en && wb_addr == addr)
        data = wb_val;
`endif
    end

    assign rs_data[i*XLEN +: XLEN] = data;
  end

  reg_file_scoreboard #(
    .NREG   (NREG),
    .NUM_RD (NUM_RD),
    .PEND_W (PEND_W),
    .AW     (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rs_addr   (rs_addr),
    .iss_en    (iss_en),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
`ifdef REG_FILE_BYPASS_EN
    .fwd_en    (wb_en && (sel != WB_NONE)),
`endif
    .rs_busy   (rs_busy)
  );

endmodule
